// File: rtl/bch_pkg.sv
// bch_pkg: shared BCH(GF(2^13)) constants, syndrome vector types and handoff FSM states.
package bch_pkg;
  localparam int BCH_M    = 13;
  localparam int BCH_NSYN = 16;
  localparam int BCH_W    = 32;
  typedef logic [BCH_M-1:0] gf_elem_t;
  typedef gf_elem_t [BCH_NSYN-1:0] syn_vec_t;
  typedef enum logic [1:0] {ACCUM, DRAIN, CAPTURE} handoff_state_t;
endpackage

// File: rtl/syn_zero_chk.sv
// syn_zero_chk: flags a syndrome set whose every element is zero (error-free codeword).
module syn_zero_chk
  import bch_pkg::*;
(
  input  syn_vec_t syn_i,
  output logic     zero_o
);
  assign zero_o = ~|syn_i;
endmodule

// File: rtl/syndrome_handoff.sv
// syndrome_handoff: feeds chunks to the syndrome bank, captures S1..S16 and hands them to the solver.
// Define SYN_ERRCNT_EN to add the saturating erroneous-codeword counter port err_cw_cnt.
module syndrome_handoff
  import bch_pkg::*;
#(
  parameter int M            = BCH_M,
  parameter int NSYN         = BCH_NSYN,
  parameter int W            = BCH_W,
  parameter int WORDS_PER_CW = 256,
  parameter int SYN_LAT      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic [W-1:0]     syn_word,
  output logic             syn_en,
  output logic             syn_clr,
  input  logic [NSYN*M-1:0] syn_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NSYN*M-1:0] out_syn,
  output logic             out_err_free
`ifdef SYN_ERRCNT_EN
  ,output logic [15:0]     err_cw_cnt
`endif
);
  localparam int CW = $clog2(WORDS_PER_CW);
  handoff_state_t state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0] lat_cnt_q, lat_cnt_d;
  logic out_valid_q, err_free_q, syn_zero, cap, last;
  logic [NSYN*M-1:0] out_syn_q;
  syn_zero_chk u_zero (.syn_i(syn_vec_t'(syn_in)), .zero_o(syn_zero));
  // Gating with reset keeps the input closed while the block is held in reset.
  assign in_ready = reset & (state_q == ACCUM);
  assign syn_en   = in_valid & in_ready;
  assign syn_word = in_data;
  assign cap      = (state_q == CAPTURE) & (~out_valid_q | out_ready);
  assign syn_clr  = ~reset | cap;
  assign last     = word_cnt_q == CW'(WORDS_PER_CW - 1);
  assign out_valid    = out_valid_q;
  assign out_syn      = out_syn_q;
  assign out_err_free = err_free_q;
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    case (state_q)
      ACCUM: if (syn_en) begin
        word_cnt_d = last ? '0 : word_cnt_q + CW'(1);
        lat_cnt_d  = '0;
        state_d    = last ? DRAIN : ACCUM;
      end
      DRAIN: begin
        lat_cnt_d = lat_cnt_q + 2'd1;
        state_d   = (lat_cnt_q == 2'(SYN_LAT - 1)) ? CAPTURE : DRAIN;
      end
      CAPTURE: state_d = cap ? ACCUM : CAPTURE;
      default: state_d = ACCUM;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ACCUM;
      word_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_syn_q   <= '0;
      err_free_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      if (cap) begin
        out_valid_q <= 1'b1;
        out_syn_q   <= syn_in;
        err_free_q  <= syn_zero;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
`ifdef SYN_ERRCNT_EN
  logic [15:0] err_cnt_q;
  assign err_cw_cnt = err_cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) err_cnt_q <= '0;
    else if (cap && !syn_zero && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_syndrome_handoff.sv
// tb_syndrome_handoff: random and directed stimulus against a codeword-level reference model.
module tb_syndrome_handoff;
  localparam int N = 4;
  localparam int LAT = 1;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, syn_en, syn_clr, out_valid, out_err_free;
  logic [31:0] in_data = 0, syn_word;
  logic [207:0] syn_in, out_syn, bank;
`ifdef SYN_ERRCNT_EN
  logic [15:0] err_cw_cnt;
`endif
  int errors = 0, checks = 0, dut_pops = 0, n_caps = 0;
  bit m_pend = 0, m_valid = 0;
  int m_wait = 0, m_cnt = 0, m_err = 0;
  logic [207:0] m_run = 0, m_pset = 0, m_set = 0;

  syndrome_handoff #(.WORDS_PER_CW(N), .SYN_LAT(LAT)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .syn_word(syn_word), .syn_en(syn_en), .syn_clr(syn_clr), .syn_in(syn_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_syn(out_syn),
`ifdef SYN_ERRCNT_EN
    .err_cw_cnt(err_cw_cnt),
`endif
    .out_err_free(out_err_free)
  );

  always #5 clk = ~clk;

  function automatic logic [207:0] fold(input logic [31:0] w);
    return {w[12:0], 163'b0, w};
  endfunction

  // Stand-in syndrome bank: one-cycle latency, order-independent XOR accumulation.
  always_ff @(posedge clk) begin
    if (syn_clr) bank <= '0;
    else if (syn_en) bank <= bank ^ fold(syn_word);
  end
  assign syn_in = bank;

  task automatic chk(input string nm, input logic [207:0] act, input logic [207:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit exp_ready, exp_cap, acc;
    #1;
    exp_ready = rst_n && !m_pend;
    exp_cap = rst_n && m_pend && m_wait >= LAT && (!m_valid || out_ready);
    chk("in_ready", in_ready, exp_ready);
    chk("syn_en", syn_en, in_valid && exp_ready);
    chk("syn_clr", syn_clr, !rst_n || exp_cap);
    chk("syn_word", syn_word, in_data);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_syn", out_syn, m_set);
      chk("out_err_free", out_err_free, m_set == 0);
    end
`ifdef SYN_ERRCNT_EN
    chk("err_cw_cnt", err_cw_cnt, m_err);
`endif
    if (out_valid && out_ready) dut_pops++;
    if (!rst_n) begin
      m_pend = 0; m_valid = 0; m_wait = 0; m_cnt = 0; m_err = 0; m_run = 0;
    end else begin
      acc = in_valid && exp_ready;
      if (exp_cap) begin
        m_valid = 1; m_set = m_pset; m_pend = 0; n_caps++;
        if (m_pset != 0 && m_err < 65535) m_err++;
      end else if (m_valid && out_ready) m_valid = 0;
      if (m_pend) m_wait++;
      if (acc) begin
        m_run ^= fold(in_data);
        m_cnt++;
        if (m_cnt == N) begin
          m_pend = 1; m_pset = m_run; m_run = 0; m_cnt = 0; m_wait = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed(input logic [31:0] d0, d1, d2, d3);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = d[i];
      cycle();
    end
    in_valid = 0;
  endtask

  initial begin
    int en_cnt;
    bit zmode;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_syn_clr", syn_clr, 1);
      chk("rst_out_syn", out_syn, 0);
      cycle();
    end
    rst_n = 1;
    #1 chk("rel_in_ready", in_ready, 1);
    feed(0, 0, 0, 0);
    #1 chk("drain_in_ready", in_ready, 0);
    chk("drain_syn_clr", syn_clr, 0);
    cycle();
    #1 chk("cap_syn_clr", syn_clr, 1);
    cycle();
    chk("zero_valid", out_valid, 1);
    chk("zero_err_free", out_err_free, 1);
    chk("zero_in_ready", in_ready, 1);
    cycle();
    out_ready = 0;
    feed(1, 0, 0, 0);
    cycle(); cycle();
    chk("err_s1", out_syn[12:0], 1);
    chk("err_set", out_syn, {13'h1, 163'b0, 32'h1});
    chk("err_err_free", out_err_free, 0);
`ifdef SYN_ERRCNT_EN
    chk("err_cnt1", err_cw_cnt, 1);
`endif
    feed(5, 6, 7, 8);
    cycle();
    in_valid = 1; in_data = 9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_syn_en", syn_en, 0);
      chk("bp_syn_clr", syn_clr, 0);
      chk("bp_hold", out_syn[12:0], 1);
      cycle();
    end
    in_valid = 0; out_ready = 1;
    #1 chk("bp_release_clr", syn_clr, 1);
    cycle();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_set", out_syn[12:0], 13'hC);
`ifdef SYN_ERRCNT_EN
    chk("err_cnt2", err_cw_cnt, 2);
`endif
    cycle();
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2) == 0;
      in_data = 32'(i + 2);
      #1 en_cnt += int'(syn_en);
      cycle();
    end
    in_valid = 0;
    cycle();
    chk("bub_accepts", en_cnt, 4);
    chk("bub_valid", out_valid, 1);
    chk("bub_set", out_syn[12:0], 13'h8);
    cycle();
    dut_pops = 0;
    in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'(i + 3);
      cycle();
    end
    in_valid = 0; rst_n = 0;
    cycle();
    rst_n = 1;
    for (int i = 0; i < 6; i++) cycle();
    chk("rstmid_pops", dut_pops, 0);
    chk("rstmid_valid", out_valid, 0);
    feed(11, 12, 13, 14);
    for (int i = 0; i < 6; i++) cycle();
    chk("rstmid_one_set", dut_pops, 1);
    zmode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_cnt == 0) zmode = $urandom_range(0, 2) == 0;
      in_valid = $urandom_range(0, 9) < 7;
      in_data = zmode ? 32'h0 : $urandom;
      out_ready = $urandom_range(0, 9) < 6;
      rst_n = $urandom_range(0, 499) != 0;
      cycle();
    end
    rst_n = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
